mmio_rd_tracker: RTL



---
 rtl/mmio_rd_tracker.sv | 111 +++++++++++
 1 files changed

// File: rtl/mmio_rd_tracker.sv
// In-order tracker for a fixed-latency MMIO read pipeline: launches reads, pairs returns with IDs, credit-limited.
// Optional statistics counters are enabled by defining MMIO_RD_TRACKER_STATS_EN.
module mmio_rd_tracker #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = 9,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TID_WIDTH-1:0]  req_tid,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TID_WIDTH-1:0]  resp_tid
`ifdef MMIO_RD_TRACKER_STATS_EN
  ,
  output logic [31:0]           stat_resp_count,
  output logic [31:0]           stat_stall_count
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]           credits_q, credits_d;
  logic [PW:0]           tid_wr_q, tid_rd_q, dat_wr_q, dat_rd_q;
  logic [TID_WIDTH-1:0]  tid_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dat_mem_q [DEPTH];

  logic fire, pop, ret_push;
  logic tid_empty, dat_empty, dat_full;

  assign tid_empty = (tid_wr_q == tid_rd_q);
  assign dat_empty = (dat_wr_q == dat_rd_q);
  assign dat_full  = (dat_wr_q[PW] != dat_rd_q[PW]) && (dat_wr_q[PW-1:0] == dat_rd_q[PW-1:0]);

  assign req_ready   = (credits_q != '0);
  assign fire        = req_valid && req_ready;
  assign mem_rd_en   = fire;
  assign mem_rd_addr = fire ? req_addr : '0;

  // A return with no outstanding ID is stale (e.g. launched before a reset) and is dropped.
  assign ret_push = mem_rd_valid && !tid_empty && !dat_full;

  assign resp_valid = !dat_empty;
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = dat_empty ? '0 : dat_mem_q[dat_rd_q[PW-1:0]];
  assign resp_tid   = tid_empty ? '0 : tid_mem_q[tid_rd_q[PW-1:0]];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    credits_d = credits_q;
    unique case ({fire, pop})
      2'b10:   credits_d = credits_q - (PW+1)'(1);
      2'b01:   credits_d = credits_q + (PW+1)'(1);
      default: credits_d = credits_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= (PW+1)'(DEPTH);
      tid_wr_q  <= '0;
      tid_rd_q  <= '0;
      dat_wr_q  <= '0;
      dat_rd_q  <= '0;
    end else begin
      credits_q <= credits_d;
      if (fire)     tid_wr_q <= tid_wr_q + (PW+1)'(1);
      if (ret_push) dat_wr_q <= dat_wr_q + (PW+1)'(1);
      if (pop) begin
        tid_rd_q <= tid_rd_q + (PW+1)'(1);
        dat_rd_q <= dat_rd_q + (PW+1)'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers mark them empty and the outputs are masked.
  always_ff @(posedge clk) begin
    if (fire)     tid_mem_q[tid_wr_q[PW-1:0]] <= req_tid;
    if (ret_push) dat_mem_q[dat_wr_q[PW-1:0]] <= mem_rd_data;
  end

`ifdef MMIO_RD_TRACKER_STATS_EN
  logic [31:0] stat_resp_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resp_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (pop && (stat_resp_q != '1))
        stat_resp_q <= stat_resp_q + 32'd1;
      if (resp_valid && !resp_ready && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_resp_count  = stat_resp_q;
  assign stat_stall_count = stat_stall_q;
`endif

endmodule
